// File: rtl/boot_pkg.sv
// Shared state encoding and core geometry constants for the pipeline boot sequencer.
package boot_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD_IM,
    LOAD_RF,
    RUN,
    DRAIN,
    DONE
  } boot_state_t;

  localparam int unsigned PIPE_STAGES = 5;
  localparam int unsigned INSTR_BYTES = 4;

  // Byte address one past the last loaded instruction word.
  function automatic logic [63:0] endPc(input logic [6:0] count);
    return 64'(count) * 64'(INSTR_BYTES);
  endfunction

endpackage

// File: rtl/pipeline_boot_sequencer_if.sv
// Loader/core-facing bundle of the boot sequencer; timeout exists only with BOOT_WATCHDOG_EN.
interface pipeline_boot_sequencer_if;

  logic        start;
  logic        ld_valid;
  logic        ld_ready;
  logic [31:0] ld_data;
  logic        ld_last;
  logic        rf_valid;
  logic        rf_ready;
  logic [63:0] rf_data;
  logic [63:0] pc_out_stage_1;
  logic        IMWrite;
  logic [31:0] instruction_in;
  logic        global_reg_write;
  logic [63:0] regfile_data_in;
  logic [4:0]  rf_index;
  logic        reset_stage_1;
  logic        busy;
  logic        done;
  logic [6:0]  instr_count;
`ifdef BOOT_WATCHDOG_EN
  logic        timeout;
`endif

  modport master (
    output start, ld_valid, ld_data, ld_last, rf_valid, rf_data, pc_out_stage_1,
    input  ld_ready, rf_ready, IMWrite, instruction_in, global_reg_write,
           regfile_data_in, rf_index, reset_stage_1, busy, done, instr_count
`ifdef BOOT_WATCHDOG_EN
    , input timeout
`endif
  );

  modport slave (
    input  start, ld_valid, ld_data, ld_last, rf_valid, rf_data, pc_out_stage_1,
    output ld_ready, rf_ready, IMWrite, instruction_in, global_reg_write,
           regfile_data_in, rf_index, reset_stage_1, busy, done, instr_count
`ifdef BOOT_WATCHDOG_EN
    , output timeout
`endif
  );

endinterface

// File: rtl/boot_load_channel.sv
// Valid/ready beat capture: presents each accepted beat as a one-cycle strobe plus held data.
module boot_load_channel #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             valid_i,
  input  logic             ready_i,
  input  logic [WIDTH-1:0] data_i,
  output logic             strobe_o,
  output logic [WIDTH-1:0] data_o
);

  logic             strobe_q;
  logic [WIDTH-1:0] data_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      strobe_q <= 1'b0;
      data_q   <= '0;
    end else begin
      strobe_q <= valid_i & ready_i;
      if (valid_i & ready_i) begin
        data_q <= data_i;
      end
    end
  end

  assign strobe_o = strobe_q;
  assign data_o   = data_q;

endmodule

// File: rtl/pipeline_boot_sequencer.sv
// Boots the 5-stage core: load IMEM, init regfile, release reset, run, drain, done.
// Defining BOOT_WATCHDOG_EN adds a RUN/DRAIN watchdog that forces DONE and raises timeout.
module pipeline_boot_sequencer
  import boot_pkg::*;
#(
  parameter int unsigned IMEM_DEPTH   = 64,
  parameter int unsigned NUM_REGS     = 32,
  parameter int unsigned DRAIN_CYCLES = PIPE_STAGES - 1
`ifdef BOOT_WATCHDOG_EN
  ,
  parameter int unsigned MAX_RUN_CYCLES = 4096
`endif
) (
  input logic clk,
  input logic reset_n,
  pipeline_boot_sequencer_if.slave bus
);

  localparam logic [6:0] LastWord  = 7'(IMEM_DEPTH - 1);
  localparam logic [4:0] LastReg   = 5'(NUM_REGS - 1);
  localparam logic [7:0] LastDrain = 8'(DRAIN_CYCLES - 1);

  boot_state_t state_q;
  logic        ldReady_q;
  logic        rfReady_q;
  logic        resetStage1_q;
  logic        busy_q;
  logic        done_q;
  logic [6:0]  instrCount_q;
  logic [4:0]  rfCount_q;
  logic [4:0]  rfIndex_q;
  logic [7:0]  drainCnt_q;
  logic        ldFire;
  logic        rfFire;
  logic        imWrite;
  logic [31:0] imData;
  logic        rfWrite;
  logic [63:0] rfData;

`ifdef BOOT_WATCHDOG_EN
  localparam logic [12:0] LastRun = 13'(MAX_RUN_CYCLES - 1);
  logic [12:0] runCnt_q;
  logic        timeout_q;
`endif

  assign ldFire = bus.ld_valid & ldReady_q;
  assign rfFire = bus.rf_valid & rfReady_q;

  boot_load_channel #(.WIDTH(32)) u_imChannel (
    .clk      (clk),
    .reset_n  (reset_n),
    .valid_i  (bus.ld_valid),
    .ready_i  (ldReady_q),
    .data_i   (bus.ld_data),
    .strobe_o (imWrite),
    .data_o   (imData)
  );

  boot_load_channel #(.WIDTH(64)) u_rfChannel (
    .clk      (clk),
    .reset_n  (reset_n),
    .valid_i  (bus.rf_valid),
    .ready_i  (rfReady_q),
    .data_i   (bus.rf_data),
    .strobe_o (rfWrite),
    .data_o   (rfData)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      ldReady_q     <= 1'b0;
      rfReady_q     <= 1'b0;
      resetStage1_q <= 1'b1;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      instrCount_q  <= '0;
      rfCount_q     <= '0;
      rfIndex_q     <= '0;
      drainCnt_q    <= '0;
`ifdef BOOT_WATCHDOG_EN
      runCnt_q      <= '0;
      timeout_q     <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (bus.start) begin
            state_q       <= LOAD_IM;
            ldReady_q     <= 1'b1;
            resetStage1_q <= 1'b1;
            busy_q        <= 1'b1;
            done_q        <= 1'b0;
            instrCount_q  <= '0;
            rfCount_q     <= '0;
`ifdef BOOT_WATCHDOG_EN
            timeout_q     <= 1'b0;
`endif
          end
        end
        LOAD_IM: begin
          if (ldFire) begin
            instrCount_q <= instrCount_q + 7'd1;
            // A full IMEM ends loading just like ld_last; ready drops so no extra beat slips in.
            if (bus.ld_last || (instrCount_q == LastWord)) begin
              state_q   <= LOAD_RF;
              ldReady_q <= 1'b0;
              rfReady_q <= 1'b1;
            end
          end
        end
        LOAD_RF: begin
          if (rfFire) begin
            rfIndex_q <= rfCount_q;
            rfCount_q <= rfCount_q + 5'd1;
            if (rfCount_q == LastReg) begin
              state_q       <= RUN;
              rfReady_q     <= 1'b0;
              resetStage1_q <= 1'b0;
`ifdef BOOT_WATCHDOG_EN
              runCnt_q      <= '0;
`endif
            end
          end
        end
        RUN: begin
          if (bus.pc_out_stage_1 >= endPc(instrCount_q)) begin
            state_q    <= DRAIN;
            drainCnt_q <= '0;
          end
        end
        DRAIN: begin
          if (drainCnt_q == LastDrain) begin
            state_q       <= DONE;
            resetStage1_q <= 1'b1;
            busy_q        <= 1'b0;
            done_q        <= 1'b1;
          end else begin
            drainCnt_q <= drainCnt_q + 8'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
`ifdef BOOT_WATCHDOG_EN
      // Watchdog overrides the normal RUN/DRAIN progression when it expires.
      if ((state_q == RUN) || (state_q == DRAIN)) begin
        if (runCnt_q == LastRun) begin
          state_q       <= DONE;
          resetStage1_q <= 1'b1;
          busy_q        <= 1'b0;
          done_q        <= 1'b1;
          timeout_q     <= 1'b1;
        end else begin
          runCnt_q <= runCnt_q + 13'd1;
        end
      end
`endif
    end
  end

  assign bus.ld_ready         = ldReady_q;
  assign bus.rf_ready         = rfReady_q;
  assign bus.IMWrite          = imWrite;
  assign bus.instruction_in   = imData;
  assign bus.global_reg_write = rfWrite;
  assign bus.regfile_data_in  = rfData;
  assign bus.rf_index         = rfIndex_q;
  assign bus.reset_stage_1    = resetStage1_q;
  assign bus.busy             = busy_q;
  assign bus.done             = done_q;
  assign bus.instr_count      = instrCount_q;
`ifdef BOOT_WATCHDOG_EN
  assign bus.timeout          = timeout_q;
`endif

endmodule

// File: tb/tb_pipeline_boot_sequencer.sv
// Directed bench for pipeline_boot_sequencer; main instance plus an IMEM_DEPTH=4 instance.
// The watchdog scenario is compiled in only when BOOT_WATCHDOG_EN is defined.
module tb_pipeline_boot_sequencer;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  pipeline_boot_sequencer_if bus ();
  pipeline_boot_sequencer_if busS ();

  pipeline_boot_sequencer #(
    .IMEM_DEPTH   (64),
    .NUM_REGS     (32),
    .DRAIN_CYCLES (4)
`ifdef BOOT_WATCHDOG_EN
    , .MAX_RUN_CYCLES (16)
`endif
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  pipeline_boot_sequencer #(
    .IMEM_DEPTH   (4),
    .NUM_REGS     (32),
    .DRAIN_CYCLES (4)
  ) dutSmall (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (busS)
  );

  task automatic idleInputs();
    bus.start = 1'b0;  bus.ld_valid = 1'b0;  bus.ld_data = '0;  bus.ld_last = 1'b0;
    bus.rf_valid = 1'b0;  bus.rf_data = '0;  bus.pc_out_stage_1 = '0;
    busS.start = 1'b0; busS.ld_valid = 1'b0; busS.ld_data = '0; busS.ld_last = 1'b0;
    busS.rf_valid = 1'b0; busS.rf_data = '0; busS.pc_out_stage_1 = '0;
  endtask

  task automatic applyStart();
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic applyRfBeats(input int n);
    for (int i = 0; i < n; i++) begin
      bus.rf_valid = 1'b1;
      bus.rf_data  = 64'(i);
      @(negedge clk);
    end
    bus.rf_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    idleInputs();
    repeat (2) @(negedge clk);
    checks++; if (bus.reset_stage_1 !== 1'b1) begin errors++; $display("[TB] FAIL reset_stage_1_in_reset got %b expected 1", bus.reset_stage_1); end
    checks++; if (bus.done !== 1'b0) begin errors++; $display("[TB] FAIL done_in_reset got %b expected 0", bus.done); end
    checks++; if (bus.ld_ready !== 1'b0) begin errors++; $display("[TB] FAIL ld_ready_in_reset got %b expected 0", bus.ld_ready); end
    checks++; if (bus.rf_ready !== 1'b0) begin errors++; $display("[TB] FAIL rf_ready_in_reset got %b expected 0", bus.rf_ready); end
    checks++; if (bus.IMWrite !== 1'b0) begin errors++; $display("[TB] FAIL imwrite_in_reset got %b expected 0", bus.IMWrite); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("[TB] FAIL busy_in_reset got %b expected 0", bus.busy); end
    checks++; if (bus.instr_count !== 7'd0) begin errors++; $display("[TB] FAIL instr_count_in_reset got %0d expected 0", bus.instr_count); end
    checks++; if (bus.instruction_in !== 32'h0) begin errors++; $display("[TB] FAIL instruction_in_reset got %h expected 0", bus.instruction_in); end
    checks++; if (busS.reset_stage_1 !== 1'b1) begin errors++; $display("[TB] FAIL small_reset_stage_1 got %b expected 1", busS.reset_stage_1); end
`ifdef BOOT_WATCHDOG_EN
    checks++; if (bus.timeout !== 1'b0) begin errors++; $display("[TB] FAIL timeout_in_reset got %b expected 0", bus.timeout); end
`endif
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (bus.ld_ready !== 1'b0) begin errors++; $display("[TB] FAIL idle_ld_ready got %b expected 0", bus.ld_ready); end
    checks++; if (bus.reset_stage_1 !== 1'b1) begin errors++; $display("[TB] FAIL idle_reset_stage_1 got %b expected 1", bus.reset_stage_1); end
  endtask

  task automatic test_load_im();
    logic [5:0]  vValid = 6'b011101;
    logic [5:0]  vLast  = 6'b001000;
    logic [5:0]  eWrite = 6'b001101;
    logic [5:0]  eLdRdy = 6'b000111;
    logic [5:0]  eRfRdy = 6'b111000;
    logic [31:0] vData [6];
    logic [31:0] eInstr [6];
    int          eCount [6];
    vData  = '{32'h00500093, 32'h00000000, 32'h00a00113, 32'h002081b3, 32'hdeadbeef, 32'h00000000};
    eInstr = '{32'h00500093, 32'h00500093, 32'h00a00113, 32'h002081b3, 32'h002081b3, 32'h002081b3};
    eCount = '{1, 1, 2, 3, 3, 3};
    applyStart();
    checks++; if (bus.ld_ready !== 1'b1) begin errors++; $display("[TB] FAIL load_im_ld_ready got %b expected 1", bus.ld_ready); end
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("[TB] FAIL load_im_busy got %b expected 1", bus.busy); end
    for (int c = 0; c < 6; c++) begin
      bus.ld_valid = vValid[c];
      bus.ld_last  = vLast[c];
      bus.ld_data  = vData[c];
      @(negedge clk);
      checks++; if (bus.IMWrite !== eWrite[c]) begin errors++; $display("[TB] FAIL load_im_imwrite c=%0d got %b expected %b", c, bus.IMWrite, eWrite[c]); end
      checks++; if (bus.instruction_in !== eInstr[c]) begin errors++; $display("[TB] FAIL load_im_instr c=%0d got %h expected %h", c, bus.instruction_in, eInstr[c]); end
      checks++; if (bus.instr_count !== 7'(eCount[c])) begin errors++; $display("[TB] FAIL load_im_count c=%0d got %0d expected %0d", c, bus.instr_count, eCount[c]); end
      checks++; if (bus.ld_ready !== eLdRdy[c]) begin errors++; $display("[TB] FAIL load_im_ld_ready c=%0d got %b expected %b", c, bus.ld_ready, eLdRdy[c]); end
      checks++; if (bus.rf_ready !== eRfRdy[c]) begin errors++; $display("[TB] FAIL load_im_rf_ready c=%0d got %b expected %b", c, bus.rf_ready, eRfRdy[c]); end
    end
    bus.ld_valid = 1'b0;
    bus.ld_last  = 1'b0;
    checks++; if (bus.reset_stage_1 !== 1'b1) begin errors++; $display("[TB] FAIL load_rf_reset_stage_1 got %b expected 1", bus.reset_stage_1); end
  endtask

  task automatic test_load_rf();
    int   sent = 0;
    int   cyc = 0;
    logic v;
    while (sent < 32 && cyc < 200) begin
      v = ((cyc % 2) == 0);
      bus.rf_valid = v;
      bus.rf_data  = 64'(sent * 3);
      @(negedge clk);
      checks++; if (bus.global_reg_write !== v) begin errors++; $display("[TB] FAIL rf_write cyc=%0d got %b expected %b", cyc, bus.global_reg_write, v); end
      if (v) begin
        checks++; if (bus.rf_index !== 5'(sent)) begin errors++; $display("[TB] FAIL rf_index got %0d expected %0d", bus.rf_index, sent); end
        checks++; if (bus.regfile_data_in !== 64'(sent * 3)) begin errors++; $display("[TB] FAIL rf_data idx=%0d got %0d expected %0d", sent, bus.regfile_data_in, sent * 3); end
        sent++;
      end
      checks++; if (bus.rf_ready !== (sent < 32)) begin errors++; $display("[TB] FAIL rf_ready sent=%0d got %b expected %b", sent, bus.rf_ready, (sent < 32)); end
      checks++; if (bus.reset_stage_1 !== (sent < 32)) begin errors++; $display("[TB] FAIL rf_reset_stage_1 sent=%0d got %b expected %b", sent, bus.reset_stage_1, (sent < 32)); end
      cyc++;
    end
    bus.rf_valid = 1'b0;
    checks++; if (sent != 32) begin errors++; $display("[TB] FAIL rf_beats_budget got %0d expected 32", sent); end
  endtask

  task automatic test_run_drain();
    logic [63:0] pcs [4];
    pcs = '{64'd0, 64'd4, 64'd8, 64'd12};
    for (int i = 0; i < 4; i++) begin
      bus.pc_out_stage_1 = pcs[i];
      @(negedge clk);
      checks++; if (bus.done !== 1'b0) begin errors++; $display("[TB] FAIL run_done pc=%0d got %b expected 0", pcs[i], bus.done); end
      checks++; if (bus.reset_stage_1 !== 1'b0) begin errors++; $display("[TB] FAIL run_reset_stage_1 pc=%0d got %b expected 0", pcs[i], bus.reset_stage_1); end
      checks++; if (bus.busy !== 1'b1) begin errors++; $display("[TB] FAIL run_busy pc=%0d got %b expected 1", pcs[i], bus.busy); end
    end
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      checks++; if (bus.done !== (k == 4)) begin errors++; $display("[TB] FAIL drain_done k=%0d got %b expected %b", k, bus.done, (k == 4)); end
      checks++; if (bus.reset_stage_1 !== (k == 4)) begin errors++; $display("[TB] FAIL drain_reset_stage_1 k=%0d got %b expected %b", k, bus.reset_stage_1, (k == 4)); end
      checks++; if (bus.busy !== (k != 4)) begin errors++; $display("[TB] FAIL drain_busy k=%0d got %b expected %b", k, bus.busy, (k != 4)); end
    end
    @(negedge clk);
    checks++; if (bus.done !== 1'b1) begin errors++; $display("[TB] FAIL done_hold got %b expected 1", bus.done); end
    checks++; if (bus.instr_count !== 7'd3) begin errors++; $display("[TB] FAIL done_instr_count got %0d expected 3", bus.instr_count); end
`ifdef BOOT_WATCHDOG_EN
    checks++; if (bus.timeout !== 1'b0) begin errors++; $display("[TB] FAIL normal_timeout got %b expected 0", bus.timeout); end
`endif
  endtask

  task automatic test_reset_mid_rf();
    bus.pc_out_stage_1 = '0;
    applyStart();
    checks++; if (bus.done !== 1'b0) begin errors++; $display("[TB] FAIL restart_done got %b expected 0", bus.done); end
    checks++; if (bus.instr_count !== 7'd0) begin errors++; $display("[TB] FAIL restart_instr_count got %0d expected 0", bus.instr_count); end
    checks++; if (bus.ld_ready !== 1'b1) begin errors++; $display("[TB] FAIL restart_ld_ready got %b expected 1", bus.ld_ready); end
    bus.ld_valid = 1'b1;
    bus.ld_last  = 1'b1;
    bus.ld_data  = 32'h00000013;
    @(negedge clk);
    bus.ld_valid = 1'b0;
    bus.ld_last  = 1'b0;
    checks++; if (bus.IMWrite !== 1'b1) begin errors++; $display("[TB] FAIL single_word_imwrite got %b expected 1", bus.IMWrite); end
    checks++; if (bus.rf_ready !== 1'b1) begin errors++; $display("[TB] FAIL single_word_rf_ready got %b expected 1", bus.rf_ready); end
    applyRfBeats(5);
    applyStart();
    checks++; if (bus.rf_ready !== 1'b1) begin errors++; $display("[TB] FAIL start_ignored_rf_ready got %b expected 1", bus.rf_ready); end
    checks++; if (bus.instr_count !== 7'd1) begin errors++; $display("[TB] FAIL start_ignored_count got %0d expected 1", bus.instr_count); end
    checks++; if (bus.rf_index !== 5'd4) begin errors++; $display("[TB] FAIL rf_index_before_reset got %0d expected 4", bus.rf_index); end
    #2 reset_n = 1'b0;
    #1;
    checks++; if (bus.rf_ready !== 1'b0) begin errors++; $display("[TB] FAIL async_reset_rf_ready got %b expected 0", bus.rf_ready); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("[TB] FAIL async_reset_busy got %b expected 0", bus.busy); end
    checks++; if (bus.instr_count !== 7'd0) begin errors++; $display("[TB] FAIL async_reset_count got %0d expected 0", bus.instr_count); end
    checks++; if (bus.rf_index !== 5'd0) begin errors++; $display("[TB] FAIL async_reset_rf_index got %0d expected 0", bus.rf_index); end
    @(posedge clk);
    #1;
    checks++; if (bus.reset_stage_1 !== 1'b1) begin errors++; $display("[TB] FAIL reset_edge_reset_stage_1 got %b expected 1", bus.reset_stage_1); end
    checks++; if (bus.ld_ready !== 1'b0) begin errors++; $display("[TB] FAIL reset_edge_ld_ready got %b expected 0", bus.ld_ready); end
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    checks++; if (bus.ld_ready !== 1'b0) begin errors++; $display("[TB] FAIL post_reset_idle_ld_ready got %b expected 0", bus.ld_ready); end
    checks++; if (bus.done !== 1'b0) begin errors++; $display("[TB] FAIL post_reset_done got %b expected 0", bus.done); end
  endtask

  task automatic test_overflow();
    logic [5:0] eWrite = 6'b001111;
    logic [5:0] eLdRdy = 6'b000111;
    logic [5:0] eRfRdy = 6'b111000;
    int         eCount [6];
    logic [31:0] eInstr [6];
    eCount = '{1, 2, 3, 4, 4, 4};
    eInstr = '{32'h100, 32'h101, 32'h102, 32'h103, 32'h103, 32'h103};
    busS.start = 1'b1;
    @(negedge clk);
    busS.start = 1'b0;
    for (int c = 0; c < 6; c++) begin
      busS.ld_valid = 1'b1;
      busS.ld_last  = 1'b0;
      busS.ld_data  = 32'h100 + 32'(c);
      @(negedge clk);
      checks++; if (busS.IMWrite !== eWrite[c]) begin errors++; $display("[TB] FAIL ovf_imwrite c=%0d got %b expected %b", c, busS.IMWrite, eWrite[c]); end
      checks++; if (busS.instruction_in !== eInstr[c]) begin errors++; $display("[TB] FAIL ovf_instr c=%0d got %h expected %h", c, busS.instruction_in, eInstr[c]); end
      checks++; if (busS.instr_count !== 7'(eCount[c])) begin errors++; $display("[TB] FAIL ovf_count c=%0d got %0d expected %0d", c, busS.instr_count, eCount[c]); end
      checks++; if (busS.ld_ready !== eLdRdy[c]) begin errors++; $display("[TB] FAIL ovf_ld_ready c=%0d got %b expected %b", c, busS.ld_ready, eLdRdy[c]); end
      checks++; if (busS.rf_ready !== eRfRdy[c]) begin errors++; $display("[TB] FAIL ovf_rf_ready c=%0d got %b expected %b", c, busS.rf_ready, eRfRdy[c]); end
    end
    busS.ld_valid = 1'b0;
  endtask

`ifdef BOOT_WATCHDOG_EN
  task automatic test_watchdog();
    int n = 0;
    bus.pc_out_stage_1 = '0;
    applyStart();
    bus.ld_valid = 1'b1;
    bus.ld_last  = 1'b1;
    bus.ld_data  = 32'h00000013;
    @(negedge clk);
    bus.ld_valid = 1'b0;
    bus.ld_last  = 1'b0;
    applyRfBeats(32);
    checks++; if (bus.reset_stage_1 !== 1'b0) begin errors++; $display("[TB] FAIL wd_run_entry got %b expected 0", bus.reset_stage_1); end
    while (bus.done !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    checks++; if (n != 16) begin errors++; $display("[TB] FAIL wd_cycles got %0d expected 16", n); end
    checks++; if (bus.timeout !== 1'b1) begin errors++; $display("[TB] FAIL wd_timeout got %b expected 1", bus.timeout); end
    checks++; if (bus.reset_stage_1 !== 1'b1) begin errors++; $display("[TB] FAIL wd_reset_stage_1 got %b expected 1", bus.reset_stage_1); end
    applyStart();
    checks++; if (bus.timeout !== 1'b0) begin errors++; $display("[TB] FAIL wd_timeout_clear got %b expected 0", bus.timeout); end
    checks++; if (bus.done !== 1'b0) begin errors++; $display("[TB] FAIL wd_done_clear got %b expected 0", bus.done); end
  endtask
`endif

  initial begin
    #200000;
    $display("[TB] FAIL global_time_limit reached at %0t", $time);
    $fatal(1, "[TB] simulation aborted");
  end

  initial begin
    $display("[TB] starting pipeline_boot_sequencer bench");
    test_reset();
    test_load_im();
    test_load_rf();
    test_run_drain();
    test_reset_mid_rf();
    test_overflow();
`ifdef BOOT_WATCHDOG_EN
    test_watchdog();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
